// File: rtl/micro_tile_switch_if.sv
`default_nettype none
// ============================================================================
// micro_tile_switch_if : pad-side select/data bus of the tile container
// Rev 1.0
// ============================================================================
interface micro_tile_switch_if #(
  parameter int N_TILES = 4,
  parameter int SEL_W   = 2,
  parameter int DATA_W  = 8
);
  logic [SEL_W-1:0]          sel_in;
  logic [N_TILES*DATA_W-1:0] tile_uo_i;
  logic [N_TILES-1:0]        tile_rst_n;
  logic [N_TILES-1:0]        tile_en;
  logic [DATA_W-1:0]         uo_out;
  logic [SEL_W-1:0]          active_sel;
  logic                      busy;
  logic [7:0]                switch_cnt;

  modport master (
    output sel_in, tile_uo_i,
    input  tile_rst_n, tile_en, uo_out, active_sel, busy, switch_cnt
  );

  modport slave (
    input  sel_in, tile_uo_i,
    output tile_rst_n, tile_en, uo_out, active_sel, busy, switch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/micro_tile_switch.sv
`default_nettype none
// ============================================================================
// micro_tile_switch : N-tile container, glitch-free drain/settle tile select
// Rev 1.0
// ============================================================================
module micro_tile_switch #(
  parameter int N_TILES     = 4,
  parameter int SEL_W       = 2,
  parameter int DATA_W      = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int SYNC_STAGES = 2
) (
  input wire clk,
  input wire rst,
  micro_tile_switch_if.slave bus
);

  localparam int C_CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t              r_state;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]    r_active_sel;
  logic [SEL_W-1:0]    r_sync [SYNC_STAGES];
  logic [N_TILES-1:0]  r_tile_rst_n;
  logic [N_TILES-1:0]  r_tile_en;
  logic [DATA_W-1:0]   r_uo_out;
  logic                r_busy;
  logic [7:0]          r_switch_cnt;

  logic [SEL_W-1:0]    w_sel_s;
  logic [N_TILES-1:0]  w_onehot;
  logic [DATA_W-1:0]   w_tile_data;

  assign w_sel_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= bus.sel_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // An out-of-range selection decodes to no tile and zero data (idle).
  always_comb begin
    w_onehot    = '0;
    w_tile_data = '0;
    for (int k = 0; k < N_TILES; k++) begin
      if (r_active_sel == SEL_W'(k)) begin
        w_onehot[k] = 1'b1;
        w_tile_data = bus.tile_uo_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SETTLE;
      r_cnt        <= '0;
      r_active_sel <= '0;
      r_tile_rst_n <= '0;
      r_tile_en    <= '0;
      r_uo_out     <= '0;
      r_busy       <= 1'b1;
      r_switch_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_sel_s != r_active_sel) begin
            r_state      <= ST_DRAIN;
            r_tile_rst_n <= '0;
            r_tile_en    <= '0;
            r_uo_out     <= '0;
            r_busy       <= 1'b1;
            if (r_switch_cnt != 8'hFF) r_switch_cnt <= r_switch_cnt + 8'd1;
          end else begin
            r_tile_rst_n <= w_onehot;
            r_tile_en    <= w_onehot;
            r_uo_out     <= w_tile_data;
            r_busy       <= 1'b0;
          end
        end
        ST_DRAIN: begin
          r_active_sel <= w_sel_s;
          r_cnt        <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // A select change while settling restarts the hold window.
          if (w_sel_s != r_active_sel) begin
            r_active_sel <= w_sel_s;
            r_cnt        <= '0;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state      <= ST_RUN;
            r_tile_rst_n <= w_onehot;
            r_tile_en    <= w_onehot;
            r_uo_out     <= '0;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= ST_SETTLE;
          r_cnt        <= '0;
          r_tile_rst_n <= '0;
          r_tile_en    <= '0;
          r_uo_out     <= '0;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tile_rst_n = r_tile_rst_n;
  assign bus.tile_en    = r_tile_en;
  assign bus.uo_out     = r_uo_out;
  assign bus.active_sel = r_active_sel;
  assign bus.busy       = r_busy;
  assign bus.switch_cnt = r_switch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_micro_tile_switch.sv
`default_nettype none
// ============================================================================
// tb_micro_tile_switch : directed scoreboard bench for micro_tile_switch
// Rev 1.0
// ============================================================================
module tb_micro_tile_switch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  micro_tile_switch_if #(.N_TILES(4), .SEL_W(2), .DATA_W(8)) if4 ();
  micro_tile_switch_if #(.N_TILES(3), .SEL_W(2), .DATA_W(8)) if3 ();

  micro_tile_switch #(.N_TILES(4), .SEL_W(2), .DATA_W(8), .SETTLE_CYC(4), .SYNC_STAGES(2))
    dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  micro_tile_switch #(.N_TILES(3), .SEL_W(2), .DATA_W(8), .SETTLE_CYC(4), .SYNC_STAGES(2))
    dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] en;
    logic [1:0] asel;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];

  // Observation mux so one set of helpers serves both instances.
  logic       use3 = 1'b0;
  logic       mon_busy;
  logic [3:0] mon_en, mon_rstn;
  logic [1:0] mon_asel;
  logic [7:0] mon_cnt, mon_uo;
  always_comb begin
    mon_busy = use3 ? if3.busy       : if4.busy;
    mon_en   = use3 ? {1'b0, if3.tile_en}    : if4.tile_en;
    mon_rstn = use3 ? {1'b0, if3.tile_rst_n} : if4.tile_rst_n;
    mon_asel = use3 ? if3.active_sel : if4.active_sel;
    mon_cnt  = use3 ? if3.switch_cnt : if4.switch_cnt;
    mon_uo   = use3 ? if3.uo_out     : if4.uo_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] en, input logic [1:0] a, input logic [7:0] c);
    exp_t e;
    e.en = en; e.asel = a; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("run_tile_en",    mon_en,   e.en);
      check("run_tile_rst_n", mon_rstn, e.en);
      check("run_active_sel", mon_asel, e.asel);
      check("run_switch_cnt", mon_cnt,  e.cnt);
      check("run_busy",       mon_busy, 0);
    end
  endtask

  task automatic wait_busy(input int exp_n);
    int   n   = 0;
    logic hit = 1'b0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      hit = mon_busy;
    end
    check("busy_rise_seen", hit, 1);
    if (exp_n > 0) check("busy_rise_cycles", n, exp_n);
  endtask

  task automatic wait_run(input int exp_n);
    int   n   = 0;
    logic hit = 1'b0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      hit = !mon_busy;
    end
    check("run_seen", hit, 1);
    if (exp_n > 0) check("run_cycles", n, exp_n);
  endtask

  // Per-cycle invariants on the 4-tile instance.
  logic [3:0] prev_en = 4'b0;
  logic       en2_seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 4'b0;
    end else begin
      check("inv_onehot", 32'($onehot0(if4.tile_en)), 1);
      check("inv_en_implies_rstn", if4.tile_en & ~if4.tile_rst_n, 0);
      if (prev_en != 4'b0 && if4.tile_en != 4'b0) check("inv_drain_gap", if4.tile_en, prev_en);
      prev_en = if4.tile_en;
      if (if4.tile_en[2]) en2_seen = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] s;
    if4.sel_in    = 2'd0;
    if4.tile_uo_i = {8'h3C, 8'h77, 8'h11, 8'hA5};
    if3.sel_in    = 2'd0;
    if3.tile_uo_i = {8'h33, 8'h22, 8'h11};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tile_en",    mon_en,   0);
    check("rst_tile_rst_n", mon_rstn, 0);
    check("rst_uo_out",     mon_uo,   0);
    check("rst_busy",       mon_busy, 1);
    check("rst_active_sel", mon_asel, 0);
    check("rst_switch_cnt", mon_cnt,  0);

    // Power-up settle onto tile 0
    rst = 1'b0;
    push(4'b0001, 2'd0, 8'd0);
    wait_run(4);
    pop_check();
    @(negedge clk);
    check("t1_uo_a5", mon_uo, 8'hA5);
    if4.tile_uo_i[7:0] = 8'h5A;
    @(negedge clk);
    check("t1_uo_track", mon_uo, 8'h5A);

    // Switch 0 -> 2
    if4.sel_in = 2'd2;
    push(4'b0100, 2'd2, 8'd1);
    wait_busy(3);
    check("t2_drain_en",   mon_en,   0);
    check("t2_drain_rstn", mon_rstn, 0);
    check("t2_drain_uo",   mon_uo,   0);
    wait_run(5);
    pop_check();
    @(negedge clk);
    check("t2_uo_tile2", mon_uo, 8'h77);

    // Re-select during settle: 0 -> 2 -> 3, tile 2 never released
    rst = 1'b1;
    if4.sel_in = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    push(4'b0001, 2'd0, 8'd0);
    wait_run(4);
    pop_check();
    en2_seen = 1'b0;
    if4.sel_in = 2'd2;
    push(4'b1000, 2'd3, 8'd1);
    wait_busy(3);
    @(negedge clk);
    if4.sel_in = 2'd3;
    wait_run(7);
    pop_check();
    check("t3_tile2_never_en", en2_seen, 0);

    // Reset mid-settle of a switch to tile 2
    if4.sel_in = 2'd2;
    wait_busy(3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_en",   mon_en,   0);
    check("t5_rst_rstn", mon_rstn, 0);
    check("t5_rst_uo",   mon_uo,   0);
    check("t5_rst_busy", mon_busy, 1);
    check("t5_rst_asel", mon_asel, 0);
    check("t5_rst_cnt",  mon_cnt,  0);
    @(negedge clk);
    rst = 1'b0;
    push(4'b0100, 2'd2, 8'd0);
    @(negedge clk);
    check("t5_post_asel", mon_asel, 0);
    check("t5_post_busy", mon_busy, 1);
    wait_run(6);
    pop_check();

    // Three-tile instance: out-of-range select is idle
    use3 = 1'b1;
    if3.sel_in = 2'd3;
    push(4'b0000, 2'd3, 8'd1);
    wait_busy(3);
    wait_run(5);
    pop_check();
    @(negedge clk);
    check("t4_idle_uo", mon_uo, 0);
    check("t4_idle_en", mon_en, 0);
    if3.sel_in = 2'd1;
    push(4'b0010, 2'd1, 8'd2);
    wait_busy(3);
    wait_run(5);
    pop_check();
    @(negedge clk);
    check("t4_uo_tile1", mon_uo, 8'h22);
    use3 = 1'b0;

    // Saturation over 300 alternating switches
    for (int i = 0; i < 300; i++) begin
      s = (i % 2 == 0) ? 2'd1 : 2'd0;
      if4.sel_in = s;
      push(4'b0001 << s, s, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      wait_busy(-1);
      wait_run(-1);
      pop_check();
    end
    check("t6_saturated", mon_cnt, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
